// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared state encoding and limits for the pipelined N-way mux.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_pkg;

    localparam int MUX_MAX_N = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mux_n_comb.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_comb
//  Description : Combinational N-way select with out-of-range flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_comb #(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int SELW  = $clog2(N)
) (
    input  logic [SELW-1:0]    i_sel,
    input  logic [N*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]   o_word,
    output logic               o_err
);

    logic [N-1:0] w_hit;

    generate
        for (genvar k = 0; k < N; k++) begin : g_hit
            assign w_hit[k] = (i_sel == SELW'(k));
        end
    endgenerate

    // Codes with no matching channel fall through to channel 0 with the flag set.
    always_comb begin
        o_word = i_data[WIDTH-1:0];
        o_err  = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (w_hit[k]) begin
                o_word = i_data[k*WIDTH +: WIDTH];
                o_err  = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mux_n_pipe
//  Description : N-way mux with registered output and 2-entry skid buffer so
//                in_ready is a flop, not a combinational path from out_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 5,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SELW-1:0]    selector,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   data_out,
    output logic               sel_err,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] w_word;
    logic             w_err;
    logic             w_accept;
    logic             w_deliver;

    state_t           r_state;
    logic [WIDTH-1:0] r_main_data;
    logic             r_main_err;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_err;
    logic             r_in_ready;
    logic             r_out_valid;

    mux_n_comb #(
        .WIDTH (WIDTH),
        .N     (N),
        .SELW  (SELW)
    ) u_sel (
        .i_sel  (selector),
        .i_data (data_in),
        .o_word (w_word),
        .o_err  (w_err)
    );

    assign w_accept  = in_valid && r_in_ready;
    assign w_deliver = r_out_valid && out_ready;

    // in_ready and out_valid are loaded from the next state, so they always
    // match r_state and never depend combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= EMPTY;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_main_data <= w_word;
                        r_main_err  <= w_err;
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_deliver) begin
                        r_main_data <= w_word;
                        r_main_err  <= w_err;
                    end else if (w_accept) begin
                        r_skid_data <= w_word;
                        r_skid_err  <= w_err;
                        r_state     <= TWO;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else if (w_deliver) begin
                        r_state     <= EMPTY;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                TWO: begin
                    if (w_deliver) begin
                        r_main_data <= r_skid_data;
                        r_main_err  <= r_skid_err;
                        r_skid_data <= '0;
                        r_skid_err  <= 1'b0;
                        r_state     <= ONE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_main_data;
    assign sel_err   = r_main_err;

endmodule
`default_nettype wire
